// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared constants, state encodings and small hazard helpers for the
// 5-stage MIPS hazard controller.
package hazard_sched_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] T_NOW  = 2'd0;
    localparam logic [1:0] T_ALU  = 2'd1;
    localparam logic [1:0] T_LOAD = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // $0 is hard-wired, so a producer writing it never matches a consumer.
    function automatic logic src_hit(input logic [4:0] cons, input logic [4:0] prod,
                                     input logic we);
        return we && (prod != 5'd0) && (cons == prod);
    endfunction

    function automatic logic tuse_late(input logic [1:0] tuse, input logic [1:0] tnew);
        return (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic e_ok, input logic m_ok,
                                            input logic w_ok);
        logic [1:0] sel;
        if (e_ok) begin
            sel = FWD_E;
        end else if (m_ok) begin
            sel = FWD_M;
        end else if (w_ok) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sched_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: stage register/timing info in,
// stall and forwarding selects out.
interface hazard_sched_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [4:0]        D_rs, D_rt;
    logic [1:0]        D_tuse_rs, D_tuse_rt;
    logic              D_is_md;
    logic [4:0]        E_rs, E_rt;
    logic [4:0]        E_wa, M_wa, W_wa;
    logic              E_regwrite, M_regwrite, W_regwrite;
    logic [1:0]        E_tnew, M_tnew;
    logic              E_md_start, E_md_div;
    logic              stall, md_busy;
    logic [1:0]        D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
    logic              M_fwd_rt;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_rs, E_rt,
               E_wa, M_wa, W_wa, E_regwrite, M_regwrite, W_regwrite,
               E_tnew, M_tnew, E_md_start, E_md_div,
        input  stall, md_busy, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt,
               M_fwd_rt, stall_count
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_rs, E_rt,
               E_wa, M_wa, W_wa, E_regwrite, M_regwrite, W_regwrite,
               E_tnew, M_tnew, E_md_start, E_md_div,
        output stall, md_busy, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt,
               M_fwd_rt, stall_count
    );
endinterface

// File: rtl/hazard_sched_ctrl_md_busy_sched.sv
// Mult/div occupancy scheduler: counts down the fixed unit latency after an
// issue so HI/LO consumers in D can be held off.
module md_busy_sched
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MD_CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_div_i,
    output logic md_busy_o
);
    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= {MD_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a start while busy is dropped, D is already stalled then.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_div_i ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
                end else begin
                    state_d = MD_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    assign md_busy_o = (state_q == MD_BUSY);

endmodule

// Checker: the pipeline must never present a new mult/div while the unit is busy.
module md_busy_chk (
    input logic clk,
    input logic reset,
    input logic md_start_i,
    input logic md_busy_i
);
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (reset) md_start_i |-> !md_busy_i
    );
endmodule

// File: rtl/hazard_sched_ctrl.sv
// Hazard controller: Tuse/Tnew stall detection, forwarding selects, mult/div
// serialisation and a saturating stall-cycle counter.
module hazard_sched_ctrl
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MD_CNT_W    = 4,
    parameter int PERF_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_sched_ctrl_if.slave hz
);
    logic              md_busy_s, data_stall_s, md_stall_s, stall_s;
    logic [1:0]        d_fwd_rs_s, d_fwd_rt_s, e_fwd_rs_s, e_fwd_rt_s;
    logic              m_fwd_rt_s;
    logic [4:0]        m_rt_q;
    logic [PERF_W-1:0] stall_count_q, stall_count_d;

    md_busy_sched #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .MD_CNT_W    (MD_CNT_W)
    ) u_md_sched (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (hz.E_md_start),
        .md_div_i   (hz.E_md_div),
        .md_busy_o  (md_busy_s)
    );

    md_busy_chk u_md_chk (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (hz.E_md_start),
        .md_busy_i  (md_busy_s)
    );

    // Stall detection and forwarding selects; W has no Tnew since it always has its data.
    always_comb begin
        data_stall_s =
            (src_hit(hz.D_rs, hz.E_wa, hz.E_regwrite) && tuse_late(hz.D_tuse_rs, hz.E_tnew)) ||
            (src_hit(hz.D_rs, hz.M_wa, hz.M_regwrite) && tuse_late(hz.D_tuse_rs, hz.M_tnew)) ||
            (src_hit(hz.D_rt, hz.E_wa, hz.E_regwrite) && tuse_late(hz.D_tuse_rt, hz.E_tnew)) ||
            (src_hit(hz.D_rt, hz.M_wa, hz.M_regwrite) && tuse_late(hz.D_tuse_rt, hz.M_tnew));
        md_stall_s = hz.D_is_md && (md_busy_s || hz.E_md_start);

        d_fwd_rs_s = fwd_pick(src_hit(hz.D_rs, hz.E_wa, hz.E_regwrite) && (hz.E_tnew == T_NOW),
                              src_hit(hz.D_rs, hz.M_wa, hz.M_regwrite) && (hz.M_tnew == T_NOW),
                              src_hit(hz.D_rs, hz.W_wa, hz.W_regwrite));
        d_fwd_rt_s = fwd_pick(src_hit(hz.D_rt, hz.E_wa, hz.E_regwrite) && (hz.E_tnew == T_NOW),
                              src_hit(hz.D_rt, hz.M_wa, hz.M_regwrite) && (hz.M_tnew == T_NOW),
                              src_hit(hz.D_rt, hz.W_wa, hz.W_regwrite));
        e_fwd_rs_s = fwd_pick(1'b0,
                              src_hit(hz.E_rs, hz.M_wa, hz.M_regwrite) && (hz.M_tnew == T_NOW),
                              src_hit(hz.E_rs, hz.W_wa, hz.W_regwrite));
        e_fwd_rt_s = fwd_pick(1'b0,
                              src_hit(hz.E_rt, hz.M_wa, hz.M_regwrite) && (hz.M_tnew == T_NOW),
                              src_hit(hz.E_rt, hz.W_wa, hz.W_regwrite));
        m_fwd_rt_s = src_hit(m_rt_q, hz.W_wa, hz.W_regwrite);
    end

    // Output stage: everything except the perf counter reads zero in a reset cycle.
    always_comb begin
        if (reset) begin
            stall_s     = 1'b0;
            hz.md_busy  = 1'b0;
            hz.D_fwd_rs = FWD_RF;
            hz.D_fwd_rt = FWD_RF;
            hz.E_fwd_rs = FWD_RF;
            hz.E_fwd_rt = FWD_RF;
            hz.M_fwd_rt = 1'b0;
        end else begin
            stall_s     = data_stall_s || md_stall_s;
            hz.md_busy  = md_busy_s;
            hz.D_fwd_rs = d_fwd_rs_s;
            hz.D_fwd_rt = d_fwd_rt_s;
            hz.E_fwd_rs = e_fwd_rs_s;
            hz.E_fwd_rt = e_fwd_rt_s;
            hz.M_fwd_rt = m_fwd_rt_s;
        end
    end

    assign hz.stall       = stall_s;
    assign hz.stall_count = stall_count_q;

    // Saturating stall counter increment.
    always_comb begin
        if (stall_s && (stall_count_q != {PERF_W{1'b1}})) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // M-stage rt tracking and perf counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_rt_q        <= 5'd0;
            stall_count_q <= {PERF_W{1'b0}};
        end else begin
            m_rt_q        <= hz.E_rt;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Scoreboard bench for hazard_sched_ctrl: directed pipeline scenarios followed
// by random traffic, checked against a cycle-level behavioural model.
module tb_hazard_sched_ctrl;
    import hazard_sched_ctrl_pkg::*;

    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_sched_ctrl_if #(.PERF_W(PW)) hz ();

    hazard_sched_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .MD_CNT_W    (4),
        .PERF_W      (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] d_rs, d_rt;
        logic [1:0] tu_rs, tu_rt;
        logic       d_md;
        logic [4:0] e_rs, e_rt, e_wa, m_wa, w_wa;
        logic       e_we, m_we, w_we;
        logic [1:0] e_tnew, m_tnew;
        logic       md_start, md_div;
    } stim_t;

    typedef struct packed {
        logic          chk;
        logic          stall, busy;
        logic [1:0]    dfrs, dfrt, efrs, efrt;
        logic          mfrt;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: cycles the mult/div unit still owes, stall tally, M-stage rt.
    int         busy_left = 0;
    int         stall_tally = 0;
    logic [4:0] m_rt_prev = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit same_reg(input logic [4:0] c, input logic [4:0] p, input logic we);
        return (we == 1'b1) && (p != 5'd0) && (c == p);
    endfunction

    function automatic bit too_early(input logic [1:0] tuse, input logic [1:0] tnew);
        return (tuse != 2'd3) && (int'(tuse) < int'(tnew));
    endfunction

    // Where a reader of register r gets its value from, nearest ready producer first.
    function automatic logic [1:0] src_of(input logic [4:0] r, input stim_t s, input bit use_e);
        if (use_e && same_reg(r, s.e_wa, s.e_we) && s.e_tnew == 2'd0) return 2'd3;
        if (same_reg(r, s.m_wa, s.m_we) && s.m_tnew == 2'd0) return 2'd1;
        if (same_reg(r, s.w_wa, s.w_we)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        bit   data_wait, md_wait;
        e     = '0;
        e.chk = 1'b1;
        e.cnt = PW'(stall_tally);
        if (s.rst) return e;
        data_wait = (same_reg(s.d_rs, s.e_wa, s.e_we) && too_early(s.tu_rs, s.e_tnew)) ||
                    (same_reg(s.d_rs, s.m_wa, s.m_we) && too_early(s.tu_rs, s.m_tnew)) ||
                    (same_reg(s.d_rt, s.e_wa, s.e_we) && too_early(s.tu_rt, s.e_tnew)) ||
                    (same_reg(s.d_rt, s.m_wa, s.m_we) && too_early(s.tu_rt, s.m_tnew));
        md_wait = s.d_md && (busy_left > 0 || s.md_start);
        e.stall = data_wait || md_wait;
        e.busy  = busy_left > 0;
        e.dfrs  = src_of(s.d_rs, s, 1'b1);
        e.dfrt  = src_of(s.d_rt, s, 1'b1);
        e.efrs  = src_of(s.e_rs, s, 1'b0);
        e.efrt  = src_of(s.e_rt, s, 1'b0);
        e.mfrt  = same_reg(m_rt_prev, s.w_wa, s.w_we);
        return e;
    endfunction

    task automatic advance(input stim_t s, input logic stalled);
        if (s.rst) begin
            busy_left   = 0;
            stall_tally = 0;
            m_rt_prev   = 5'd0;
        end else begin
            if (stalled && stall_tally < (1 << PW) - 1) stall_tally++;
            if (busy_left > 0) busy_left--;
            else if (s.md_start) busy_left = s.md_div ? 10 : 5;
            m_rt_prev = s.e_rt;
        end
    endtask

    task automatic step(input stim_t s, input bit chk_en);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = s.rst;
        hz.D_rs       = s.d_rs;     hz.D_rt       = s.d_rt;
        hz.D_tuse_rs  = s.tu_rs;    hz.D_tuse_rt  = s.tu_rt;
        hz.D_is_md    = s.d_md;
        hz.E_rs       = s.e_rs;     hz.E_rt       = s.e_rt;
        hz.E_wa       = s.e_wa;     hz.M_wa       = s.m_wa;    hz.W_wa = s.w_wa;
        hz.E_regwrite = s.e_we;     hz.M_regwrite = s.m_we;    hz.W_regwrite = s.w_we;
        hz.E_tnew     = s.e_tnew;   hz.M_tnew     = s.m_tnew;
        hz.E_md_start = s.md_start; hz.E_md_div   = s.md_div;
        e     = model(s);
        e.chk = chk_en;
        sbq.push_back(e);
        advance(s, e.stall);
    endtask

    // Monitor: every cycle is an output cycle for this block, compare away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
                chk("stall",       32'(hz.stall),       32'(e.stall));
                chk("md_busy",     32'(hz.md_busy),     32'(e.busy));
                chk("D_fwd_rs",    32'(hz.D_fwd_rs),    32'(e.dfrs));
                chk("D_fwd_rt",    32'(hz.D_fwd_rt),    32'(e.dfrt));
                chk("E_fwd_rs",    32'(hz.E_fwd_rs),    32'(e.efrs));
                chk("E_fwd_rt",    32'(hz.E_fwd_rt),    32'(e.efrt));
                chk("M_fwd_rt",    32'(hz.M_fwd_rt),    32'(e.mfrt));
                chk("stall_count", 32'(hz.stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        stim_t idle, s;
        idle = '0;
        s    = '0;
        reset = 1'b1;

        s = idle; s.rst = 1'b1;
        step(s, 1'b0);
        step(s, 1'b1);

        // lw $8 in E, beq on $8 in D: two bubbles, then W forward
        s = idle; s.e_wa = 5'd8; s.e_we = 1'b1; s.e_tnew = T_LOAD; s.d_rs = 5'd8;
        step(s, 1'b1);
        s = idle; s.m_wa = 5'd8; s.m_we = 1'b1; s.m_tnew = T_ALU; s.d_rs = 5'd8;
        step(s, 1'b1);
        s = idle; s.w_wa = 5'd8; s.w_we = 1'b1; s.d_rs = 5'd8;
        step(s, 1'b1);
        step(idle, 1'b1);
        @(negedge clk);
        chk("plan1_stall_count", 32'(hz.stall_count), 32'd2);

        // addu $9 then dependent addu with Tuse=1
        s = idle; s.e_wa = 5'd9; s.e_we = 1'b1; s.e_tnew = T_ALU; s.d_rs = 5'd9; s.tu_rs = 2'd1;
        step(s, 1'b1);
        s = idle; s.m_wa = 5'd9; s.m_we = 1'b1; s.m_tnew = 2'd0; s.e_rs = 5'd9; s.e_rt = 5'd12;
        step(s, 1'b1);
        s = idle; s.w_wa = 5'd12; s.w_we = 1'b1;
        step(s, 1'b1);

        // jal link forwarded from E to jr, and $0 never matching
        s = idle; s.e_wa = 5'd31; s.e_we = 1'b1; s.d_rs = 5'd31; s.d_rt = 5'd31;
        step(s, 1'b1);
        s.e_wa = 5'd0; s.d_rs = 5'd0;
        step(s, 1'b1);

        // div with a HI/LO reader waiting in D
        s = idle; s.md_start = 1'b1; s.md_div = 1'b1; s.d_md = 1'b1;
        step(s, 1'b1);
        s = idle; s.d_md = 1'b1;
        for (int i = 0; i < 12; i++) step(s, 1'b1);

        // mult, then reset while a div is mid-countdown
        s = idle; s.md_start = 1'b1; s.d_md = 1'b1;
        step(s, 1'b1);
        s = idle; s.d_md = 1'b1;
        for (int i = 0; i < 7; i++) step(s, 1'b1);
        s = idle; s.md_start = 1'b1; s.md_div = 1'b1;
        step(s, 1'b1);
        for (int i = 0; i < 6; i++) step(idle, 1'b1);
        s = idle; s.rst = 1'b1;
        step(s, 1'b1);
        step(idle, 1'b1);
        @(negedge clk);
        chk("plan5_md_busy", 32'(hz.md_busy), 32'd0);
        chk("plan5_stall_count", 32'(hz.stall_count), 32'd0);

        // continuous load-use stall until the counter saturates
        s = idle; s.e_wa = 5'd5; s.e_we = 1'b1; s.e_tnew = T_LOAD; s.d_rt = 5'd5;
        for (int i = 0; i < 20; i++) step(s, 1'b1);
        @(negedge clk);
        chk("plan6_saturate", 32'(hz.stall_count), 32'd15);

        // random traffic over a small register window to force frequent matches
        for (int i = 0; i < 400; i++) begin
            s        = '0;
            s.rst    = ($urandom_range(0, 59) == 0);
            s.d_rs   = 5'($urandom_range(0, 3));
            s.d_rt   = 5'($urandom_range(0, 3));
            s.tu_rs  = 2'($urandom_range(0, 3));
            s.tu_rt  = 2'($urandom_range(0, 3));
            s.d_md   = ($urandom_range(0, 3) == 0);
            s.e_rs   = 5'($urandom_range(0, 3));
            s.e_rt   = 5'($urandom_range(0, 3));
            s.e_wa   = 5'($urandom_range(0, 3));
            s.m_wa   = 5'($urandom_range(0, 3));
            s.w_wa   = 5'($urandom_range(0, 3));
            s.e_we   = 1'($urandom_range(0, 1));
            s.m_we   = 1'($urandom_range(0, 1));
            s.w_we   = 1'($urandom_range(0, 1));
            s.e_tnew = 2'($urandom_range(0, 2));
            s.m_tnew = 2'($urandom_range(0, 1));
            s.md_start = (busy_left == 0) && ($urandom_range(0, 7) == 0);
            s.md_div   = 1'($urandom_range(0, 1));
            step(s, 1'b1);
        end

        step(idle, 1'b1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Compares D-stage register use times (Tuse) against E/M/W producer times (Tnew), which the EX→MEM register decrements per stage.
- Drives the PC/IF-ID hold, the ID-EX bubble and all forwarding mux selects.
- Owns the mult/div busy scheduler, serialising HI/LO access, and a stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.
- MD_CNT_W, 4, width of the busy countdown; must hold DIV_CYCLES.
- PERF_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- D_rs, D_rt  in  5 each  source registers of the instruction in D
- D_tuse_rs, D_tuse_rt  in  2 each  cycles until operand needed (0 = in D, 1 = in E, 2 = in M; 3 = unused)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_rs, E_rt  in  5 each  sources of the instruction in E
- E_wa, M_wa, W_wa  in  5 each  destination register per stage
- E_regwrite, M_regwrite, W_regwrite  in  1 each  stage writes the GPR file
- E_tnew, M_tnew  in  2 each  remaining cycles until result is valid
- E_md_start  in  1  mult/div occupying E this cycle (one cycle pulse)
- E_md_div  in  1  1 = div type, 0 = mult type; qualified by E_md_start
- stall  out  1  hold PC and IF/ID; insert bubble in ID/EX
- md_busy  out  1  mult/div unit occupied
- D_fwd_rs, D_fwd_rt  out  2 each  D comparator/branch operand select
- E_fwd_rs, E_fwd_rt  out  2 each  ALU operand select
- M_fwd_rt  out  1  store-data select: 1 = W write data
- stall_count  out  PERF_W  total stalled cycles since reset

Behaviour:
- Producer matches a consumer iff: address equal, address ≠ 0, regwrite = 1.
- Forward encoding: 0 = GPR/pipe value, 1 = from M, 2 = from W, 3 = from E (E_tnew = 0 only, e.g. jal link).
- E and M sources are eligible only when their tnew = 0. W is always eligible.
- Forward priority: E > M > W. D selects use E/M/W; E selects use M/W. M_fwd_rt = 1 iff W matches M_rt.
- M_rt is not a port: the M stage rt is taken as the registered E_rt delayed one cycle internally (m_rt_q), cleared on reset.
- Data stall: any matched E or M producer with Tuse < Tnew. A Tuse value of 3 never stalls.
- MD stall: D_is_md and (md_busy or E_md_start).
- stall = data stall OR md stall; it is combinational, same cycle.
- MD FSM has two states, IDLE and BUSY:
  - IDLE → BUSY on E_md_start; counter loads DIV_CYCLES if E_md_div, else MULT_CYCLES.
  - BUSY: counter decrements each cycle; BUSY → IDLE when counter reaches 1→0.
  - E_md_start is ignored while BUSY. It cannot occur, because D is stalled; assert-only check.
  - md_busy = (state == BUSY).
- stall_count increments by 1 on every cycle with stall = 1 and saturates at all-ones.
- Reset (synchronous, any cycle, including mid-BUSY):
  - State → IDLE, counter → 0, m_rt_q → 0, stall_count → 0.
  - During the reset cycle, stall, md_busy and all fwd outputs are forced to 0.
- Simultaneous matched producers: data stall takes precedence, and forward selects still compute. The bubble masks them.

Decomposition:
- Shared package holds:
  - FWD_RF=0, FWD_M=1, FWD_W=2, FWD_E=3.
  - TUSE_NONE=3.
  - Tnew constants T_ALU=1, T_LOAD=2.
  - MD state encodings.
- One sub-module, md_busy_sched: FSM, countdown and md_busy. The rest stays in this block.

Test Plan:
1. E: lw $8, E_tnew=2; D: beq with $8, Tuse=0 → stall=1 for 2 cycles; then D_fwd_rs=2 (W); stall_count=2.
2. E: addu $9, E_tnew=1; D: addu using $9, Tuse=1 → no stall. Next cycle M_tnew=0 → E_fwd_rs=1.
3. E: jal, E_wa=31, E_tnew=0; D: jr $31, Tuse=0 → D_fwd_rs=3, stall=0. With E_wa=0 instead → D_fwd_rs=0.
4. E_md_start with E_md_div=1, then D_is_md=1 for 12 cycles → md_busy high 10 cycles; stall=1 on the start cycle plus 10 busy cycles; released on cycle 11.
5. Reset asserted at busy count 4 → next cycle md_busy=0, stall=0, stall_count=0.
6. Force stall continuously for 2^PERF_W cycles (PERF_W=4 in the bench) → stall_count saturates at 15.
